// File: rtl/ps2_receiver.sv
// ----------------------------------------------------------------------------
// ps2_receiver
//
// Turns the raw PS/2 keyboard line into 8-bit scan-code bytes. Both PS/2 lines
// are synchronized, the PS/2 clock is glitch-filtered, and an 11-bit frame
// (start, 8 data LSB-first, odd parity, stop) is assembled on each filtered
// falling edge. A correctly framed byte gives a one-cycle oFlag strobe with the
// byte on oData. A framing error or a stalled frame gives a one-cycle oErr
// strobe instead.
//
// Optional feature macro: PS2_PARITY_CHECK_EN
//   defined     -> the parity bit is checked; a parity failure raises oErr.
//   not defined -> the parity bit is consumed but ignored.
//
// Parameters:
//   FILTER_LEN      identical synchronized clock samples needed to change the
//                   filtered clock level (2..32)
//   TIMEOUT_CYCLES  iClk cycles without a filtered falling edge that abort a
//                   frame in progress
//
// Ports:
//   iClk      system clock, rising edge
//   iReset_n  asynchronous active-low reset
//   iPs2Clk   raw PS/2 clock (asynchronous)
//   iPs2Data  raw PS/2 data (asynchronous)
//   oData     last valid byte received
//   oFlag     one-cycle strobe, oData has just been updated
//   oErr      one-cycle strobe on frame error or timeout
// ----------------------------------------------------------------------------
module ps2_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       iClk,
    input  logic       iReset_n,
    input  logic       iPs2Clk,
    input  logic       iPs2Data,
    output logic [7:0] oData,
    output logic       oFlag,
    output logic       oErr
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    // The counter value in the last stall cycle before the frame is abandoned.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Synchronizers (reset to the idle-high line level)
    logic clk_s1_q, clk_s2_q;
    logic dat_s1_q, dat_s2_q;

    // Glitch filter
    logic [FILTER_LEN-1:0] filt_sr_q, filt_sr_d;
    logic                  filt_clk_q, filt_clk_d;
    logic                  fall_event;

    // Frame assembly
    state_t            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        sh_q, sh_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [7:0]        data_q, data_d;
    logic              flag_q, flag_d;
    logic              err_q, err_d;
    logic              frame_ok;
`ifdef PS2_PARITY_CHECK_EN
    logic              par_q, par_d;
`endif

    // ------------------------------------------------------------------
    // Filter: the level only changes once every tap agrees.
    // ------------------------------------------------------------------
    always_comb begin
        filt_sr_d  = {filt_sr_q[FILTER_LEN-2:0], clk_s2_q};
        filt_clk_d = filt_clk_q;
        if (filt_sr_q == '0) begin
            filt_clk_d = 1'b0;
        end else if (&filt_sr_q) begin
            filt_clk_d = 1'b1;
        end
    end

    // Single-cycle strobe in the cycle the filtered clock commits to low.
    assign fall_event = filt_clk_q & ~filt_clk_d;

    // Stop bit must be 1; with the parity check enabled, data plus parity
    // must also carry an odd number of ones.
`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok = dat_s2_q & (^{sh_q, par_q});
`else
    assign frame_ok = dat_s2_q;
`endif

    // ------------------------------------------------------------------
    // Frame FSM, timeout and output strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        to_cnt_d  = '0;
        data_d    = data_q;
        flag_d    = 1'b0;
        err_d     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_d     = par_q;
`endif

        // A fall event wins over expiry in the same cycle, so expiry is only
        // evaluated when there is no fall event.
        if (state_q != IDLE) begin
            if (fall_event) begin
                to_cnt_d = '0;
            end else if (to_cnt_q == TO_LAST) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (fall_event && !dat_s2_q) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (fall_event) begin
                    sh_d      = {dat_s2_q, sh_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall_event) begin
`ifdef PS2_PARITY_CHECK_EN
                    par_d   = dat_s2_q;
`endif
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall_event) begin
                    if (frame_ok) begin
                        data_d = sh_q;
                        flag_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            filt_sr_q  <= '1;
            filt_clk_q <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            sh_q       <= 8'h00;
            to_cnt_q   <= '0;
            data_q     <= 8'h00;
            flag_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_q      <= 1'b0;
`endif
        end else begin
            clk_s1_q   <= iPs2Clk;
            clk_s2_q   <= clk_s1_q;
            dat_s1_q   <= iPs2Data;
            dat_s2_q   <= dat_s1_q;
            filt_sr_q  <= filt_sr_d;
            filt_clk_q <= filt_clk_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sh_q       <= sh_d;
            to_cnt_q   <= to_cnt_d;
            data_q     <= data_d;
            flag_q     <= flag_d;
            err_q      <= err_d;
`ifdef PS2_PARITY_CHECK_EN
            par_q      <= par_d;
`endif
        end
    end

    assign oData = data_q;
    assign oFlag = flag_q;
    assign oErr  = err_q;

endmodule
